// File: rtl/fulladd.sv
// -----------------------------------------------------------------------------
// fulladd
//   WIDTH-bit ripple-carry adder with registered outputs:
//   {Cout, s} = x + y + Cin. The sum is not truncated because the carry out
//   of the top bit is kept. With WIDTH=1 the block is a single full-adder cell.
//   The result registers load only on cycles where in_valid is high, and the
//   out_valid flag marks that the registers hold a freshly accepted result.
//
// Ports
//   clk        in   1      single clock; all state changes on its rising edge
//   rst        in   1      synchronous, active-high reset; wins over in_valid
//   in_valid   in   1      Cin/x/y carry a new operand set this cycle
//   Cin        in   1      carry into bit 0
//   x          in   WIDTH  operand A (unsigned)
//   y          in   WIDTH  operand B (unsigned)
//   s          out  WIDTH  registered sum bits (wraps modulo 2^WIDTH)
//   Cout       out  1      registered carry out of bit WIDTH-1
//   out_valid  out  1      high for one cycle after each accepted input
// -----------------------------------------------------------------------------
module fulladd #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             Cin,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s,
    output logic             Cout,
    output logic             out_valid
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;

    logic [WIDTH-1:0] s_reg;
    logic             cout_reg;
    logic             valid_reg;

    // The carry chain is built in one process so that each bit is written
    // before the next bit reads it. This keeps the ripple a plain
    // combinational chain without a self-referencing vector across processes.
    always_comb begin
        carry    = '0;
        carry[0] = Cin;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = (x[i] & y[i]) | (x[i] & carry[i]) | (y[i] & carry[i]);
        end
    end

    // The sum bits only read the carry chain, so each bit is an independent cell.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sum_bit
            assign sum_next[gi] = x[gi] ^ y[gi] ^ carry[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg     <= '0;
            cout_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            // The result registers hold through idle cycles, so a downstream
            // stage may re-read the last result; only the valid flag drops.
            valid_reg <= in_valid;
            if (in_valid) begin
                s_reg    <= sum_next;
                cout_reg <= carry[WIDTH];
            end
        end
    end

    assign s         = s_reg;
    assign Cout      = cout_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_fulladd.sv
// -----------------------------------------------------------------------------
// tb_fulladd
//   Self-checking bench for fulladd. It runs a WIDTH=1 instance (the single
//   full-adder cell) and a WIDTH=8 instance side by side on one clock. Inputs
//   are driven 1 time unit after a rising edge, and outputs are sampled 1 time
//   unit after the next rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fulladd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared reset for both instances.
    logic rst;

    // WIDTH=1 instance
    logic       iv1, cin1;
    logic [0:0] x1, y1, s1;
    logic       cout1, ov1;

    // WIDTH=8 instance
    logic       iv8, cin8;
    logic [7:0] x8, y8, s8;
    logic       cout8, ov8;

    int checks = 0;
    int errors = 0;

    fulladd #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .Cin(cin1),
        .x(x1), .y(y1), .s(s1), .Cout(cout1), .out_valid(ov1)
    );

    fulladd #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .Cin(cin8),
        .x(x8), .y(y8), .s(s8), .Cout(cout8), .out_valid(ov8)
    );

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        iv1  = 1'b1; cin1 = 1'b1; x1 = 1'b1;  y1 = 1'b1;
        iv8  = 1'b1; cin8 = 1'b1; x8 = 8'hFF; y8 = 8'hFF;
        tick();
        tick();
        $display("reset: w1 s=%0d Cout=%0d ov=%0d | w8 s=%02h Cout=%0d ov=%0d",
                 s1, cout1, ov1, s8, cout8, ov8);
        checks++; if (s1 !== 1'b0)    begin errors++; $display("FAIL reset_s1: got %0d want 0", s1); end
        checks++; if (cout1 !== 1'b0) begin errors++; $display("FAIL reset_cout1: got %0d want 0", cout1); end
        checks++; if (ov1 !== 1'b0)   begin errors++; $display("FAIL reset_ov1: got %0d want 0", ov1); end
        checks++; if (s8 !== 8'h00)   begin errors++; $display("FAIL reset_s8: got %02h want 00", s8); end
        checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL reset_cout8: got %0d want 0", cout8); end
        checks++; if (ov8 !== 1'b0)   begin errors++; $display("FAIL reset_ov8: got %0d want 0", ov8); end
        rst = 1'b0;
        iv1 = 1'b0;
        iv8 = 1'b0;
        tick();
    endtask

    // Truth table indexed by {Cin,x,y}: the sum is odd parity, and the carry is the majority.
    task automatic test_exhaustive();
        logic [7:0] exp_s_tab;
        logic [7:0] exp_c_tab;
        logic [2:0] combo;
        bit         stop;
        exp_s_tab = 8'b1001_0110;
        exp_c_tab = 8'b1110_1000;
        stop = 0;
        for (int i = 0; i < 8 && !stop; i++) begin
            combo = 3'(i);
            iv1 = 1'b1; cin1 = combo[2]; x1 = combo[1]; y1 = combo[0];
            tick();
            $display("exhaustive {Cin,x,y}=%03b: s=%0d Cout=%0d ov=%0d", combo, s1, cout1, ov1);
            checks++;
            if (s1 !== exp_s_tab[i] || cout1 !== exp_c_tab[i] || ov1 !== 1'b1) begin
                errors++;
                $display("FAIL exhaustive {Cin,x,y}=%03b: got s/Cout/ov=%0d/%0d/%0d want %0d/%0d/1",
                         combo, s1, cout1, ov1, exp_s_tab[i], exp_c_tab[i]);
                stop = 1;
            end
        end
        iv1 = 1'b0;
    endtask

    task automatic test_hold();
        iv1 = 1'b1; cin1 = 1'b0; x1 = 1'b1; y1 = 1'b1;
        tick();
        checks++;
        if (s1 !== 1'b0 || cout1 !== 1'b1 || ov1 !== 1'b1) begin
            errors++;
            $display("FAIL hold_load: got s/Cout/ov=%0d/%0d/%0d want 0/1/1", s1, cout1, ov1);
        end
        for (int k = 0; k < 3; k++) begin
            iv1 = 1'b0; cin1 = ~cin1; x1 = ~x1; y1 = 1'(k);
            tick();
            $display("hold cycle %0d: s=%0d Cout=%0d ov=%0d", k, s1, cout1, ov1);
            checks++;
            if (s1 !== 1'b0 || cout1 !== 1'b1 || ov1 !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: got s/Cout/ov=%0d/%0d/%0d want 0/1/0", k, s1, cout1, ov1);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] vx [3];
        logic [7:0] vy [3];
        logic       vc [3];
        logic [8:0] vexp [3];
        vx[0] = 8'hFF; vy[0] = 8'h01; vc[0] = 1'b0; vexp[0] = 9'h100;
        vx[1] = 8'h7F; vy[1] = 8'h80; vc[1] = 1'b1; vexp[1] = 9'h100;
        vx[2] = 8'h12; vy[2] = 8'h34; vc[2] = 1'b1; vexp[2] = 9'h047;
        for (int i = 0; i < 3; i++) begin
            iv8 = 1'b1; x8 = vx[i]; y8 = vy[i]; cin8 = vc[i];
            tick();
            $display("w8 %02h+%02h+%0d: Cout=%0d s=%02h ov=%0d", vx[i], vy[i], vc[i], cout8, s8, ov8);
            checks++;
            if ({cout8, s8} !== vexp[i] || ov8 !== 1'b1) begin
                errors++;
                $display("FAIL overflow_%0d: got {Cout,s}=%03h ov=%0d want %03h ov=1",
                         i, {cout8, s8}, ov8, vexp[i]);
            end
        end
        iv8 = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [8:0] expv;
        for (int i = 0; i < 1000; i++) begin
            iv8  = 1'b1;
            x8   = 8'($urandom_range(0, 255));
            y8   = 8'($urandom_range(0, 255));
            cin8 = 1'($urandom_range(0, 1));
            expv = {1'b0, x8} + {1'b0, y8} + {8'b0, cin8};
            tick();
            $display("b2b %0d: %02h+%02h+%0d -> %03h", i, x8, y8, cin8, {cout8, s8});
            checks++;
            if ({cout8, s8} !== expv || ov8 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d: got {Cout,s}=%03h ov=%0d want %03h ov=1", i, {cout8, s8}, ov8, expv);
            end
        end
        iv8 = 1'b0;
        tick();
    endtask

    task automatic test_midstream_reset();
        iv8 = 1'b1; x8 = 8'hA5; y8 = 8'h5A; cin8 = 1'b1;
        tick();
        checks++;
        if ({cout8, s8} !== 9'h100 || ov8 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got {Cout,s}=%03h ov=%0d want 100 ov=1", {cout8, s8}, ov8);
        end
        rst = 1'b1; x8 = 8'hC3; y8 = 8'h3C; cin8 = 1'b0;
        tick();
        $display("midrst during reset: Cout=%0d s=%02h ov=%0d", cout8, s8, ov8);
        checks++;
        if ({cout8, s8} !== 9'h000 || ov8 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: got {Cout,s}=%03h ov=%0d want 000 ov=0", {cout8, s8}, ov8);
        end
        rst = 1'b0; x8 = 8'h80; y8 = 8'h81; cin8 = 1'b1;
        tick();
        $display("midrst after release: Cout=%0d s=%02h ov=%0d", cout8, s8, ov8);
        checks++;
        if ({cout8, s8} !== 9'h102 || ov8 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_resume: got {Cout,s}=%03h ov=%0d want 102 ov=1", {cout8, s8}, ov8);
        end
        iv8 = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        iv1 = 1'b0; cin1 = 1'b0; x1 = 1'b0; y1 = 1'b0;
        iv8 = 1'b0; cin8 = 1'b0; x8 = 8'h00; y8 = 8'h00;
        #1;
        test_reset();
        test_exhaustive();
        test_hold();
        test_overflow();
        test_back_to_back();
        test_midstream_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
